// File: rtl/mult_arbiter.sv
// Arbiter and sequencer sharing one add-shift multiplier among N_REQ requesters.
// Define MULT_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module mult_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     n_reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic [2*WIDTH-1:0]       result,
  output logic                     busy,
  output logic                     mult_start,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic                     mult_ready,
  input  logic [2*WIDTH-1:0]       mult_product
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitLow,
    StWaitHigh,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0]    winner_q;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    search_start;
  logic               win_found;
  logic               served_q;
  logic [N_REQ-1:0]   winner_oh;
  logic [N_REQ-1:0]   eligible;
  logic [WIDTH-1:0]   mult_a_q, mult_b_q;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [2*WIDTH-1:0] result_q;

  assign winner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << winner_q;
  // The requester just served sits out the first idle cycle after its done pulse.
  assign eligible  = served_q ? (req & ~winner_oh) : req;

`ifdef MULT_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ptr_q <= '0;
    end else if (state_q == StDone) begin
      ptr_q <= (winner_q == IdxW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
    end
  end

  assign search_start = ptr_q;
`else
  assign search_start = '0;
`endif

  // Circular search from search_start; first eligible index wins.
  always_comb begin : p_search
    logic [IdxW:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, search_start} + (IdxW + 1)'(i);
      if (cand >= (IdxW + 1)'(N_REQ)) begin
        cand = cand - (IdxW + 1)'(N_REQ);
      end
      if (!win_found && eligible[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == IdxW'(k)) begin
        sel_a = a_in[k*WIDTH +: WIDTH];
        sel_b = b_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (win_found) state_d = StLoad;
      StLoad:     state_d = StStart;
      StStart:    state_d = StWaitLow;
      StWaitLow:  if (!mult_ready) state_d = StWaitHigh;
      StWaitHigh: if (mult_ready) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    grant      = '0;
    done       = '0;
    mult_start = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle: ;
      StLoad, StWaitLow, StWaitHigh: grant = winner_oh;
      StStart: begin
        grant      = winner_oh;
        mult_start = 1'b1;
      end
      StDone: begin
        grant = winner_oh;
        done  = winner_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      winner_q <= '0;
      served_q <= 1'b0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      result_q <= '0;
    end else begin
      served_q <= (state_q == StDone);
      if (state_q == StIdle && win_found) begin
        winner_q <= win_idx;
        mult_a_q <= sel_a;
        mult_b_q <= sel_b;
      end
      if (state_q == StWaitHigh && mult_ready) begin
        result_q <= mult_product;
      end
    end
  end

  assign mult_a = mult_a_q;
  assign mult_b = mult_b_q;
  assign result = result_q;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer sharing one add-shift multiplier (sequencer plus datapath) among `N_REQ` requesters. Latches the winning requester's operands, launches the multiplier, waits for completion and returns the product with a one-cycle done pulse to that requester. Sits between client blocks and the single multiplier instance; it is the only driver of the multiplier's start and operand inputs.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `WIDTH`, 4: operand width; product is `2*WIDTH`
- `clock` in 1: system clock, rising edge
- `n_reset` in 1: asynchronous, active-low reset
- `req` in N_REQ: request level per requester
- `a_in` in N_REQ*WIDTH: operand A, requester k at bits [k*WIDTH +: WIDTH]
- `b_in` in N_REQ*WIDTH: operand B, same packing
- `grant` out N_REQ: one-hot, high for the served requester from LOAD through DONE
- `done` out N_REQ: one-hot, one-cycle pulse in DONE
- `result` out 2*WIDTH: registered product, held until the next DONE
- `busy` out 1: high in every state except IDLE
- `mult_start` out 1: one-cycle launch pulse to the multiplier
- `mult_a`, `mult_b` out WIDTH: registered operands to the multiplier
- `mult_ready` in 1: multiplier idle/finished flag
- `mult_product` in 2*WIDTH: multiplier output, valid while `mult_ready`=1 after an operation

## Operation
- States: IDLE, LOAD, START, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE: if any eligible `req`, select winner k, register `a_in[k]`/`b_in[k]` into `mult_a`/`mult_b`, go to LOAD. Otherwise stay in IDLE.
- LOAD: `grant[k]`=1, operands stable; go to START.
- START: `mult_start`=1 for exactly this cycle; go to WAIT_LOW.
- WAIT_LOW: wait until `mult_ready`=0 (multiplier accepted the launch); go to WAIT_HIGH.
- WAIT_HIGH: wait until `mult_ready`=1. On that edge, capture `mult_product` into `result`; go to DONE.
- DONE: `done[k]`=1, `grant[k]`=1; go to IDLE. In the first IDLE cycle after DONE, `req[k]` of the just-served requester is masked.
- `mult_a`/`mult_b` change only in IDLE on a win. They hold their value from LOAD through DONE.
- `req[k]` dropping after grant does not abort. The operation completes and `done[k]` still pulses.
- `a_in`/`b_in` are sampled only at the win. Later changes are ignored.
- Winner selection (round-robin build): search starts at `ptr`. `ptr` loads (k+1) mod N_REQ in DONE.
- Reset values: state IDLE, `ptr`=0, `grant`=0, `done`=0, `result`=0, `busy`=0, `mult_start`=0, `mult_a`=0, `mult_b`=0.
- Reset mid-operation clears all state immediately. No done pulse is issued. The multiplier is not reset by this block.

## Timing
- Win registered at edge t (IDLE→LOAD). LOAD at t+1, START at t+2, WAIT_LOW from t+3.
- Minimum win-to-done: 5 cycles plus multiplier latency. `done` is asserted in the cycle after `mult_ready` is first seen high in WAIT_HIGH.
- `result` is valid from the DONE cycle onward, stable until the next DONE.
- Back-to-back: a different requester can win in the IDLE cycle immediately after DONE (one idle cycle between operations).
- Simultaneous requests: exactly one grant per operation. Losers keep `req` high and are served later.
- `mult_ready` already 0 in START: WAIT_LOW exits on the next cycle. A multiplier that never drops ready hangs in WAIT_LOW (no timeout).

## Configuration
- `MULT_ARB_ROUND_ROBIN_EN` defined: round-robin from `ptr` as above.
- Undefined: fixed priority, lowest eligible index wins. `ptr` is not implemented. The post-DONE mask still applies.

## Test plan
- Single request, WIDTH=4: `req`=0001, a=3, b=5 → `grant`=0001 from LOAD to DONE, one `mult_start` pulse, `done`=0001 pulse, `result`=15, `busy` back to 0.
- Max operands: a=15, b=15 on requester 2 → `result`=225, `done`=0100.
- Contention: `req`=1111 held, round-robin → winners 0,1,2,3,0 in order, one done per operation. Fixed-priority build → requester 0 re-wins whenever eligible.
- Operand change after win: a_in[1] 6→9 in START, b=2 → `result`=12 and `mult_a` stays 6.
- Requester drops `req` during WAIT_HIGH → `done` still pulses, result correct, next winner selected normally.
- `n_reset` low during WAIT_HIGH → all outputs 0 asynchronously, state IDLE, no `done`. After release, a new request on requester 3 wins, since `ptr`=0 and no other request is pending.
